// File: rtl/mem_arb_defs.sv
// Shared encodings and helpers for the I/D memory-port arbiter.
package mem_arb_defs;

  localparam int unsigned ST_W  = 2;
  localparam int unsigned CNT_W = 8;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_GNT_I = 2'd1;
  localparam logic [ST_W-1:0] ST_GNT_D = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Round-robin pick: on contention the side that did not win last time goes.
  function automatic logic pick_grant(input logic i_req, input logic d_req,
                                      input logic last_grant);
    logic grant;
    if (i_req && d_req) begin
      grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      grant = GRANT_D;
    end else begin
      grant = GRANT_I;
    end
    return grant;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Cycle counter bounding how long a grant state may wait for the memory.
module arb_timeout_counter
  import mem_arb_defs::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over enable; saturate rather than wrap.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry: the last allowed grant cycle has been reached.
  assign expire_c = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic cnt_clr;
  logic cnt_en;
  logic expire;
  logic grant;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expire_c (expire)
  );

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    grant        = pick_grant(i_req_i, d_req_i, last_grant_q);

    case (state_q)
      ST_IDLE: begin
        if (i_req_i || d_req_i) begin
          last_grant_d = grant;
          mem_req_d    = 1'b1;
          cnt_clr      = 1'b1;
          if (grant == GRANT_D) begin
            state_d     = ST_GNT_D;
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
          end else begin
            state_d     = ST_GNT_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr_i;
            mem_wdata_d = '0;
          end
        end
      end

      ST_GNT_I, ST_GNT_D: begin
        cnt_en = 1'b1;
        if (mem_ack_i) begin
          // A real ack beats a simultaneous timeout.
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          if (state_q == ST_GNT_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata_i;
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end
        end else if (expire) begin
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
          err_d     = 1'b1;
          if (state_q == ST_GNT_I) begin
            i_ack_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_ack_o     = i_ack_q;
  assign d_ack_o     = d_ack_q;
  assign err_o       = err_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  // Stall while any requester is still waiting for its ack.
  assign stall_o = (i_req_i & ~i_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack_o, d_ack_o, err_o, mem_req_o, mem_we_o, stall_o;
  logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who won last, and the last successful read per side.
  bit          last_d;
  logic [31:0] i_rd_m, d_rd_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .stall_o(stall_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom;
  endtask

  task automatic new_d(input bit we);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = $urandom;
    d_wdata = $urandom;
  endtask

  // One arbitrated transaction; called in an IDLE cycle with at least one request up.
  // lat: memory ack delay after mem_req_o rises (>= TO means the memory never acks).
  task automatic run_round(input int lat, input logic [31:0] rd, input bit keep);
    bit          win_d, exp_err, exp_we;
    int          wait_c;
    logic [31:0] exp_addr, exp_wdata;
    win_d     = (i_req && d_req) ? !last_d : d_req;
    last_d    = win_d;
    exp_addr  = win_d ? d_addr : i_addr;
    exp_wdata = d_wdata;
    exp_we    = win_d && d_we;
    exp_err   = (lat > TO - 1);
    wait_c    = exp_err ? TO - 1 : lat;
    tick();
    check_eq("mem_req_rise", 64'(mem_req_o), 64'd1);
    check_eq("mem_addr", 64'(mem_addr_o), 64'(exp_addr));
    check_eq("mem_we", 64'(mem_we_o), 64'(exp_we));
    if (win_d) check_eq("mem_wdata", 64'(mem_wdata_o), 64'(exp_wdata));
    for (int k = 0; k <= wait_c; k++) begin
      check_eq("wait_acks", 64'({i_ack_o, d_ack_o, err_o}), 64'd0);
      check_eq("wait_req", 64'(mem_req_o), 64'd1);
      check_eq("wait_addr", 64'(mem_addr_o), 64'(exp_addr));
      check_eq("wait_stall", 64'(stall_o), 64'd1);
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? rd : 32'($urandom);
      tick();
    end
    // Completion cycle: a stray memory ack here must be ignored.
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    check_eq("i_ack", 64'(i_ack_o), 64'(!win_d));
    check_eq("d_ack", 64'(d_ack_o), 64'(win_d));
    check_eq("err", 64'(err_o), 64'(exp_err));
    check_eq("done_req", 64'(mem_req_o), 64'd0);
    if (!exp_err && !exp_we) begin
      if (win_d) d_rd_m = rd;
      else       i_rd_m = rd;
    end
    check_eq("i_rdata", 64'(i_rdata_o), 64'(i_rd_m));
    check_eq("d_rdata", 64'(d_rdata_o), 64'(d_rd_m));
    check_eq("done_stall", 64'(stall_o), 64'(win_d ? i_req : d_req));
    if (keep) begin
      if (win_d) new_d(1'($urandom_range(0, 1)));
      else       new_i();
    end else begin
      if (win_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end
    tick();
    mem_ack = 1'b0;
    check_eq("idle_acks", 64'({i_ack_o, d_ack_o, err_o}), 64'd0);
    check_eq("idle_req", 64'(mem_req_o), 64'd0);
  endtask

  // Quiet cycles with no requests; a late memory ack must not produce anything.
  task automatic idle_quiet(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ack = (k == 1);
      tick();
      check_eq("quiet_acks", 64'({i_ack_o, d_ack_o, err_o}), 64'd0);
      check_eq("quiet_req", 64'(mem_req_o), 64'd0);
      check_eq("quiet_stall", 64'(stall_o), 64'd0);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    last_d = 1'b0; i_rd_m = '0; d_rd_m = '0;
    tick(); tick();
    check_eq("rst_outs", 64'({mem_req_o, mem_we_o, i_ack_o, d_ack_o, err_o, stall_o}), 64'd0);
    check_eq("rst_addr", 64'(mem_addr_o), 64'd0);
    check_eq("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check_eq("rst_rdata", {i_rdata_o, d_rdata_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Both from reset: D write first, then I read.
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'h1234;
    i_req = 1; i_addr = 32'h40;
    run_round(2, 32'hCAFE0000, 1'b0);
    run_round(2, 32'hDEADBEEF, 1'b0);

    // Continuous contention alternates D, I, D, I; then drain.
    new_i(); new_d(1'b0);
    for (int r = 0; r < 4; r++) run_round($urandom_range(0, 3), $urandom, 1'b1);
    run_round(1, $urandom, 1'b0);
    run_round(0, $urandom, 1'b0);

    // D read timing out, followed by a late ack in IDLE.
    new_d(1'b0);
    run_round(100, 32'h55AA55AA, 1'b0);
    idle_quiet(4);

    // Ack in the very cycle the counter expires.
    new_i();
    run_round(TO - 1, 32'h0BADF00D, 1'b0);
    new_d(1'b0);
    run_round(TO - 1, 32'hFEEDFACE, 1'b0);

    // Reset while I is granted.
    i_req = 1; i_addr = 32'h80;
    tick();
    check_eq("pre_rst_req", 64'(mem_req_o), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_req", 64'(mem_req_o), 64'd0);
    i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    last_d = 1'b0; i_rd_m = '0; d_rd_m = '0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("stale_ack", 64'({i_ack_o, d_ack_o, err_o, mem_req_o}), 64'd0);
    check_eq("rst_i_rdata", 64'(i_rdata_o), 64'(i_rd_m));
    mem_ack = 1'b0;
    tick();

    // Randomized traffic.
    for (int r = 0; r < 80; r++) begin
      if (!i_req && ($urandom_range(0, 1) == 1)) new_i();
      if (!d_req && ($urandom_range(0, 1) == 1)) new_d(1'($urandom_range(0, 1)));
      if (!i_req && !d_req) begin
        if ($urandom_range(0, 1) == 1) new_i();
        else new_d(1'($urandom_range(0, 1)));
      end
      run_round($urandom_range(0, 9), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
